// File: rtl/score_digit_if.sv
// ---------------------------------------------------------------------------
// score_digit_if
// Bundles the beam/score inputs and the renderer/score outputs of
// score_digit_scheduler.
//   master : drives pix_en, frame_tick, xpos, ypos, point_p1, point_p2, clear;
//            observes digit_x/y/val/active, score_p1/p2, game_over, winner
//   slave  : the scheduler side (mirror of master)
// ---------------------------------------------------------------------------
interface score_digit_if;
    logic        pix_en;
    logic        frame_tick;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic        point_p1;
    logic        point_p2;
    logic        clear;
    logic [9:0]  digit_x;
    logic [9:0]  digit_y;
    logic [3:0]  digit_val;
    logic        digit_active;
    logic [7:0]  score_p1;
    logic [7:0]  score_p2;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output pix_en, frame_tick, xpos, ypos, point_p1, point_p2, clear,
        input  digit_x, digit_y, digit_val, digit_active,
               score_p1, score_p2, game_over, winner
    );

    modport slave (
        input  pix_en, frame_tick, xpos, ypos, point_p1, point_p2, clear,
        output digit_x, digit_y, digit_val, digit_active,
               score_p1, score_p2, game_over, winner
    );
endinterface

// File: rtl/score_digit_scheduler.sv
// ---------------------------------------------------------------------------
// score_digit_scheduler
// Keeps both player scores as BCD counters, detects the end of the game and
// time-shares one 7-segment pixel renderer among the four score digits
// (P1 tens/ones, P2 tens/ones). Each pix_en cycle the digit window holding
// the beam is located and its origin/value are registered for the renderer,
// one pixel behind the beam.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : score_digit_if.slave
//            in : pix_en, frame_tick, xpos, ypos, point_p1, point_p2, clear
//            out: digit_x, digit_y, digit_val, digit_active,
//                 score_p1, score_p2, game_over, winner
//
// Optional build macro SCORE_BLINK_EN: blinks the winner's digits at
// BLINK_DIV frames per half-period once the game is over.
// ---------------------------------------------------------------------------
module score_digit_scheduler #(
    parameter logic [9:0] P1_X        = 10'd240,
    parameter logic [9:0] P2_X        = 10'd360,
    parameter logic [9:0] DIGIT_Y     = 10'd16,
    parameter logic [9:0] DIGIT_PITCH = 10'd24,
    parameter logic [9:0] DIGIT_W     = 10'd20,
    parameter logic [9:0] DIGIT_H     = 10'd28,
    parameter logic [6:0] WIN_SCORE   = 7'd11,
    parameter logic [5:0] BLINK_DIV   = 6'd30
) (
    input  logic          clk,
    input  logic          rst_n,
    score_digit_if.slave  bus
);

    localparam logic [0:0] ST_PLAY = 1'b0;
    localparam logic [0:0] ST_OVER = 1'b1;

    localparam logic [9:0] X_P1T = P1_X;
    localparam logic [9:0] X_P1O = P1_X + DIGIT_PITCH;
    localparam logic [9:0] X_P2T = P2_X;
    localparam logic [9:0] X_P2O = P2_X + DIGIT_PITCH;

    // BCD increment; the whole score holds at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99)
            return s;
        if (s[3:0] == 4'd9)
            return {s[7:4] + 4'd1, 4'd0};
        return {s[7:4], s[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] s);
        return {3'd0, s[7:4]} * 7'd10 + {3'd0, s[3:0]};
    endfunction

    function automatic logic in_win(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] x0);
        logic [10:0] x_hi;
        logic [10:0] y_hi;
        x_hi = {1'b0, x0} + {1'b0, DIGIT_W} - 11'd1;
        y_hi = {1'b0, DIGIT_Y} + {1'b0, DIGIT_H} - 11'd1;
        return (x >= x0) && ({1'b0, x} <= x_hi) &&
               (y >= DIGIT_Y) && ({1'b0, y} <= y_hi);
    endfunction

    logic [0:0] r_state;
    logic [7:0] r_score_p1;
    logic [7:0] r_score_p2;
    logic [1:0] r_winner;

    logic       w_play;
    logic       w_p1_inc;
    logic       w_p2_inc;
    logic [7:0] w_p1_next;
    logic [7:0] w_p2_next;
    logic       w_p1_win;
    logic       w_p2_win;

    // Win is judged on the post-increment score so game_over rises together
    // with the winning score.
    assign w_play    = (r_state == ST_PLAY);
    assign w_p1_inc  = w_play & bus.point_p1;
    assign w_p2_inc  = w_play & bus.point_p2;
    assign w_p1_next = w_p1_inc ? bcd_inc(r_score_p1) : r_score_p1;
    assign w_p2_next = w_p2_inc ? bcd_inc(r_score_p2) : r_score_p2;
    assign w_p1_win  = w_p1_inc && (bcd_to_bin(w_p1_next) == WIN_SCORE);
    assign w_p2_win  = w_p2_inc && (bcd_to_bin(w_p2_next) == WIN_SCORE);

    // ---- score / game state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_PLAY;
            r_score_p1 <= 8'h00;
            r_score_p2 <= 8'h00;
            r_winner   <= 2'b00;
        end else if (bus.clear) begin
            r_state    <= ST_PLAY;
            r_score_p1 <= 8'h00;
            r_score_p2 <= 8'h00;
            r_winner   <= 2'b00;
        end else if (w_play) begin
            r_score_p1 <= w_p1_next;
            r_score_p2 <= w_p2_next;
            if (w_p1_win || w_p2_win) begin
                r_state  <= ST_OVER;
                r_winner <= {w_p2_win, w_p1_win};
            end
        end
    end

    logic w_blink_p1;
    logic w_blink_p2;

`ifdef SCORE_BLINK_EN
    logic [5:0] r_frame_cnt;
    logic       r_phase;

    // Holding the counter clear throughout PLAY makes every OVER entry start
    // from frame 0 with the digits visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 6'd0;
            r_phase     <= 1'b0;
        end else if (r_state == ST_PLAY) begin
            r_frame_cnt <= 6'd0;
            r_phase     <= 1'b0;
        end else if (bus.frame_tick) begin
            if (r_frame_cnt == BLINK_DIV - 6'd1) begin
                r_frame_cnt <= 6'd0;
                r_phase     <= ~r_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
        end
    end

    assign w_blink_p1 = r_phase & r_winner[0];
    assign w_blink_p2 = r_phase & r_winner[1];
`else
    logic w_unused_frame_tick;
    assign w_unused_frame_tick = bus.frame_tick;
    assign w_blink_p1 = 1'b0;
    assign w_blink_p2 = 1'b0;
`endif

    // ---- window select (fixed priority P1T > P1O > P2T > P2O) ----
    logic       w_hit;
    logic [9:0] w_x;
    logic [3:0] w_val;
    logic       w_tens;
    logic       w_blank;
    logic       w_act;

    always_comb begin
        w_hit   = 1'b0;
        w_x     = X_P1T;
        w_val   = 4'd0;
        w_tens  = 1'b0;
        w_blank = 1'b0;
        if (in_win(bus.xpos, bus.ypos, X_P1T)) begin
            w_hit   = 1'b1;
            w_x     = X_P1T;
            w_val   = r_score_p1[7:4];
            w_tens  = 1'b1;
            w_blank = w_blink_p1;
        end else if (in_win(bus.xpos, bus.ypos, X_P1O)) begin
            w_hit   = 1'b1;
            w_x     = X_P1O;
            w_val   = r_score_p1[3:0];
            w_blank = w_blink_p1;
        end else if (in_win(bus.xpos, bus.ypos, X_P2T)) begin
            w_hit   = 1'b1;
            w_x     = X_P2T;
            w_val   = r_score_p2[7:4];
            w_tens  = 1'b1;
            w_blank = w_blink_p2;
        end else if (in_win(bus.xpos, bus.ypos, X_P2O)) begin
            w_hit   = 1'b1;
            w_x     = X_P2O;
            w_val   = r_score_p2[3:0];
            w_blank = w_blink_p2;
        end
    end

    // A zero tens digit is blanked but its origin/value still go out.
    assign w_act = w_hit & ~(w_tens & (w_val == 4'd0)) & ~w_blank;

    // ---- renderer register stage (one pixel behind the beam) ----
    logic [9:0] r_dx_p1;
    logic [9:0] r_dy_p1;
    logic [3:0] r_dval_p1;
    logic       r_dact_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dx_p1   <= P1_X;
            r_dy_p1   <= DIGIT_Y;
            r_dval_p1 <= 4'd0;
            r_dact_p1 <= 1'b0;
        end else if (bus.pix_en) begin
            r_dact_p1 <= w_act;
            if (w_hit) begin
                r_dx_p1   <= w_x;
                r_dy_p1   <= DIGIT_Y;
                r_dval_p1 <= w_val;
            end
        end
    end

    assign bus.digit_x      = r_dx_p1;
    assign bus.digit_y      = r_dy_p1;
    assign bus.digit_val    = r_dval_p1;
    assign bus.digit_active = r_dact_p1;
    assign bus.score_p1     = r_score_p1;
    assign bus.score_p2     = r_score_p2;
    assign bus.game_over    = (r_state == ST_OVER);
    assign bus.winner       = r_winner;

endmodule

// File: tb/tb_score_digit_scheduler.sv
module tb_score_digit_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_digit_if bus();

    score_digit_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] dx;
        logic [3:0] val;
        logic       act;
    } pix_vec_t;

    pix_vec_t vecs[21];
    pix_vec_t sb[$];

    int n_checks = 0;
    int n_err    = 0;
    logic pix_sampled = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) pix_sampled <= bus.pix_en & rst_n;

    // Scoreboard: one expected record per sampled pix_en.
    always @(negedge clk) begin
        if (pix_sampled) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                pix_vec_t e;
                e = sb.pop_front();
                chk($sformatf("digit_x(%0d,%0d)", e.x, e.y), {22'd0, bus.digit_x}, {22'd0, e.dx});
                chk($sformatf("digit_y(%0d,%0d)", e.x, e.y), {22'd0, bus.digit_y}, 32'd16);
                chk($sformatf("digit_val(%0d,%0d)", e.x, e.y), {28'd0, bus.digit_val}, {28'd0, e.val});
                chk($sformatf("digit_active(%0d,%0d)", e.x, e.y), {31'd0, bus.digit_active}, {31'd0, e.act});
            end
        end
    end

    task automatic pix(input pix_vec_t v);
        @(negedge clk);
        bus.pix_en = 1'b1;
        bus.xpos   = v.x;
        bus.ypos   = v.y;
        sb.push_back(v);
        @(negedge clk);
        bus.pix_en = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) pix(vecs[i]);
    endtask

    task automatic pulse(input logic p1, input logic p2, input logic clr, input logic ft);
        @(negedge clk);
        bus.point_p1   = p1;
        bus.point_p2   = p2;
        bus.clear      = clr;
        bus.frame_tick = ft;
        @(negedge clk);
        bus.point_p1   = 1'b0;
        bus.point_p2   = 1'b0;
        bus.clear      = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic chk_game(input string tag, input logic [7:0] s1, input logic [7:0] s2,
                            input logic go, input logic [1:0] w);
        chk({tag, "_score_p1"}, {24'd0, bus.score_p1}, {24'd0, s1});
        chk({tag, "_score_p2"}, {24'd0, bus.score_p2}, {24'd0, s2});
        chk({tag, "_game_over"}, {31'd0, bus.game_over}, {31'd0, go});
        chk({tag, "_winner"}, {30'd0, bus.winner}, {30'd0, w});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            x     y     dx    val  act
        vecs[0]  = '{10'd245, 10'd20, 10'd240, 4'd0, 1'b0}; // P1 tens, blanked zero
        vecs[1]  = '{10'd265, 10'd20, 10'd264, 4'd0, 1'b1}; // P1 ones
        vecs[2]  = '{10'd380, 10'd43, 10'd264, 4'd0, 1'b0}; // gap between P2 digits
        vecs[3]  = '{10'd360, 10'd16, 10'd360, 4'd0, 1'b0}; // P2 tens corner
        vecs[4]  = '{10'd403, 10'd43, 10'd384, 4'd0, 1'b1}; // P2 ones far corner
        vecs[5]  = '{10'd404, 10'd43, 10'd384, 4'd0, 1'b0}; // one right of it
        vecs[6]  = '{10'd403, 10'd44, 10'd384, 4'd0, 1'b0}; // one below it
        vecs[7]  = '{10'd259, 10'd20, 10'd240, 4'd0, 1'b0}; // P1 tens last column
        vecs[8]  = '{10'd260, 10'd20, 10'd240, 4'd0, 1'b0}; // gap
        vecs[9]  = '{10'd264, 10'd15, 10'd240, 4'd0, 1'b0}; // row above
        vecs[10] = '{10'd264, 10'd16, 10'd264, 4'd0, 1'b1}; // P1 ones first pixel
        // score 10 : 00
        vecs[11] = '{10'd241, 10'd17, 10'd240, 4'd1, 1'b1};
        vecs[12] = '{10'd300, 10'd17, 10'd240, 4'd1, 1'b0};
        vecs[13] = '{10'd268, 10'd17, 10'd264, 4'd0, 1'b1};
        vecs[14] = '{10'd365, 10'd17, 10'd360, 4'd0, 1'b0};
        // score 11 : 11, game over
        vecs[15] = '{10'd385, 10'd20, 10'd384, 4'd1, 1'b1};
        vecs[16] = '{10'd241, 10'd17, 10'd240, 4'd1, 1'b1};
        // P1 win 11 : 00 (blink-phase checks and reset test)
        vecs[17] = '{10'd268, 10'd17, 10'd264, 4'd1, 1'b1};
        vecs[18] = '{10'd268, 10'd17, 10'd264, 4'd1, 1'b0};
        vecs[19] = '{10'd385, 10'd20, 10'd384, 4'd0, 1'b1};
        vecs[20] = '{10'd241, 10'd17, 10'd240, 4'd1, 1'b1};

        bus.pix_en = 1'b0; bus.frame_tick = 1'b0;
        bus.xpos = 10'd0; bus.ypos = 10'd0;
        bus.point_p1 = 1'b0; bus.point_p2 = 1'b0; bus.clear = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_digit_x", {22'd0, bus.digit_x}, 32'd240);
        chk("rst_digit_y", {22'd0, bus.digit_y}, 32'd16);
        chk("rst_digit_val", {28'd0, bus.digit_val}, 32'd0);
        chk("rst_digit_active", {31'd0, bus.digit_active}, 32'd0);
        chk_game("rst", 8'h00, 8'h00, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        run_vecs(0, 10);

        // pix_en low: a hit position must not move the outputs
        @(negedge clk);
        bus.xpos = 10'd241;
        bus.ypos = 10'd17;
        @(negedge clk);
        chk("hold_digit_x", {22'd0, bus.digit_x}, 32'd264);
        chk("hold_digit_active", {31'd0, bus.digit_active}, 32'd1);

        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk_game("p1_ten", 8'h10, 8'h00, 1'b0, 2'b00);
        run_vecs(11, 14);

        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_game("p2_ten", 8'h10, 8'h10, 1'b0, 2'b00);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk_game("tie", 8'h11, 8'h11, 1'b1, 2'b11);
        run_vecs(15, 16);

        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_game("over_ignore", 8'h11, 8'h11, 1'b1, 2'b11);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk_game("clear", 8'h00, 8'h00, 1'b0, 2'b00);

        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk_game("p1_ten_b", 8'h10, 8'h00, 1'b0, 2'b00);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk_game("p1_win", 8'h11, 8'h00, 1'b1, 2'b01);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk_game("p1_win_hold", 8'h11, 8'h00, 1'b1, 2'b01);

`ifdef SCORE_BLINK_EN
        for (int i = 0; i < 29; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pix(vecs[17]);                       // frame 29: visible
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pix(vecs[18]);                       // frame 30: P1 blanked
        pix(vecs[19]);                       // P2 still shown
        for (int i = 0; i < 30; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pix(vecs[17]);                       // frame 60: visible again
`else
        for (int i = 0; i < 30; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pix(vecs[17]);
        pix(vecs[19]);
`endif

        // Async reset while active and game over
        pix(vecs[20]);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_digit_active", {31'd0, bus.digit_active}, 32'd0);
        chk("arst_digit_x", {22'd0, bus.digit_x}, 32'd240);
        chk("arst_digit_val", {28'd0, bus.digit_val}, 32'd0);
        chk_game("arst", 8'h00, 8'h00, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
